dma_cycle_monitor: RTL and testbench

DMA_CYCLE_MONITOR -- requirements
Module: dma_cycle_monitor

---
 rtl/dma_cycle_monitor_pkg.sv | 35 +++
 rtl/dma_cycle_monitor_if.sv | 29 ++
 rtl/dma_cycle_monitor_sync_ff.sv | 31 +++
 rtl/dma_cycle_monitor.sv | 176 +++++++++++++++++
 tb/tb_dma_cycle_monitor.sv | 205 ++++++++++++++++++++
 5 files changed

// File: rtl/dma_cycle_monitor_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : dma_cycle_monitor_pkg
//  Description : Shared state encodings, STATUS bit positions and helpers
//                for the Zorro DMA cycle monitor.
//  Revision    : 1.0  initial release
// ============================================================================
package dma_cycle_monitor_pkg;

    // Monitor FSM state encodings
    typedef enum logic [1:0] {
        MON_IDLE   = 2'd0,
        MON_ACTIVE = 2'd1,
        MON_DONE   = 2'd2,
        MON_FAULT  = 2'd3
    } mon_state_e;

    // STATUS word layout: {sticky_berr, sticky_timeout, busy, 0, fault_cnt}
    localparam int c_STAT_BERR_BIT = 7;
    localparam int c_STAT_TMO_BIT  = 6;
    localparam int c_STAT_BUSY_BIT = 5;
    localparam int c_STAT_RSVD_BIT = 4;
    localparam int c_STAT_CNT_MSB  = 3;
    localparam int c_STAT_CNT_LSB  = 0;

    localparam int c_CNT_W  = 10;
    localparam int c_FCNT_W = 4;

    // Increment that sticks at all-ones instead of wrapping
    function automatic logic [c_FCNT_W-1:0] sat_inc_fcnt(input logic [c_FCNT_W-1:0] v);
        return (v == {c_FCNT_W{1'b1}}) ? v : v + {{(c_FCNT_W-1){1'b0}}, 1'b1};
    endfunction

endpackage
`default_nettype wire

// File: rtl/dma_cycle_monitor_if.sv
`default_nettype none
// ============================================================================
//  Module      : dma_cycle_monitor_if
//  Description : DMA engine / Zorro side signals seen by the cycle monitor.
//  Revision    : 1.0  initial release
// ============================================================================
interface dma_cycle_monitor_if;
    logic       bmaster;    // card owns the bus as DMA master
    logic       dma_fcs_n;  // FCS_n from the DMA engine
    logic       dtack_n;    // Zorro DTACK_n, asynchronous
    logic       berr_n;     // Zorro BERR_n, asynchronous
    logic       stat_clr;   // clears sticky status and fault count
    logic       dma_abort;  // ask the engine to drop FCS
    logic       cycle_ok;   // one pulse per normally terminated cycle
    logic [7:0] status;

    // Driver side (DMA engine / bus environment)
    modport master (
        output bmaster, dma_fcs_n, dtack_n, berr_n, stat_clr,
        input  dma_abort, cycle_ok, status
    );

    // Monitor side
    modport slave (
        input  bmaster, dma_fcs_n, dtack_n, berr_n, stat_clr,
        output dma_abort, cycle_ok, status
    );
endinterface
`default_nettype wire

// File: rtl/dma_cycle_monitor_sync_ff.sv
`default_nettype none
// ============================================================================
//  Module      : sync_ff
//  Description : Multi-flop synchronizer for one asynchronous input; flops
//                reset to 1 so inactive-low bus signals read as idle.
//  Revision    : 1.0  initial release
// ============================================================================
module sync_ff #(
    parameter int STAGES = 2
) (
    input  wire logic clk,
    input  wire logic rst,
    input  wire logic i_d,
    output logic      o_q
);

    logic [STAGES-1:0] r_sh;

    // Shift the raw input through the synchronizer chain
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sh <= '1;
        end else begin
            r_sh <= {r_sh[STAGES-2:0], i_d};
        end
    end

    assign o_q = r_sh[STAGES-1];

endmodule
`default_nettype wire

// File: rtl/dma_cycle_monitor.sv
`default_nettype none
// ============================================================================
//  Module      : dma_cycle_monitor
//  Description : Watches Zorro DMA master cycles; flags normal completion,
//                bus errors and DTACK timeouts, and requests an abort of
//                faulted cycles.
//  Revision    : 1.0  initial release
// ============================================================================
module dma_cycle_monitor
    import dma_cycle_monitor_pkg::*;
#(
    parameter int TIMEOUT     = 1000,
    parameter int SYNC_STAGES = 2
) (
    input  wire logic          clk,
    input  wire logic          rst,
    dma_cycle_monitor_if.slave bus
);

    localparam logic [c_CNT_W-1:0] c_TO_LAST = c_CNT_W'(TIMEOUT - 1);

    logic                w_dtack_s;
    logic                w_berr_s;

    mon_state_e          r_state;
    mon_state_e          w_state_nxt;
    logic                w_fault_berr;
    logic                w_fault_tmo;
    logic                w_done;

    logic [c_CNT_W-1:0]  r_cnt;
    logic                r_dma_abort;
    logic                r_cycle_ok;
    logic                r_busy;
    logic                r_sticky_berr;
    logic                r_sticky_tmo;
    logic [c_FCNT_W-1:0] r_fault_cnt;

    logic                w_sticky_berr_nxt;
    logic                w_sticky_tmo_nxt;
    logic [c_FCNT_W-1:0] w_fault_cnt_nxt;
    logic [7:0]          w_status;

    sync_ff #(.STAGES(SYNC_STAGES)) u_sync_dtack (
        .clk (clk),
        .rst (rst),
        .i_d (bus.dtack_n),
        .o_q (w_dtack_s)
    );

    sync_ff #(.STAGES(SYNC_STAGES)) u_sync_berr (
        .clk (clk),
        .rst (rst),
        .i_d (bus.berr_n),
        .o_q (w_berr_s)
    );

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= MON_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic; losing bus mastership overrides every other event,
    // and within ACTIVE a bus error beats DTACK which beats the timeout
    always_comb begin
        w_state_nxt  = r_state;
        w_fault_berr = 1'b0;
        w_fault_tmo  = 1'b0;
        w_done       = 1'b0;
        if ((r_state != MON_IDLE) && !bus.bmaster) begin
            w_state_nxt = MON_IDLE;
        end else begin
            case (r_state)
                MON_IDLE: begin
                    if (bus.bmaster && !bus.dma_fcs_n) begin
                        w_state_nxt = MON_ACTIVE;
                    end
                end
                MON_ACTIVE: begin
                    if (!w_berr_s) begin
                        w_state_nxt  = MON_FAULT;
                        w_fault_berr = 1'b1;
                    end else if (!w_dtack_s) begin
                        w_state_nxt = MON_DONE;
                        w_done      = 1'b1;
                    end else if (r_cnt == c_TO_LAST) begin
                        w_state_nxt = MON_FAULT;
                        w_fault_tmo = 1'b1;
                    end else if (bus.dma_fcs_n) begin
                        // engine gave up on the cycle itself
                        w_state_nxt = MON_IDLE;
                    end
                end
                MON_DONE: begin
                    if (bus.dma_fcs_n) begin
                        w_state_nxt = MON_IDLE;
                    end
                end
                MON_FAULT: begin
                    if (bus.dma_fcs_n && w_berr_s) begin
                        w_state_nxt = MON_IDLE;
                    end
                end
                default: begin
                    w_state_nxt = MON_IDLE;
                end
            endcase
        end
    end

    // Cycle length counter: zeroed on cycle start, saturating while ACTIVE
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt <= '0;
        end else if ((r_state == MON_IDLE) && (w_state_nxt == MON_ACTIVE)) begin
            r_cnt <= '0;
        end else if ((r_state == MON_ACTIVE) && (r_cnt != '1)) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    // Sticky status update; a fault on the clearing edge still lands
    always_comb begin
        w_sticky_berr_nxt = bus.stat_clr ? 1'b0 : r_sticky_berr;
        w_sticky_tmo_nxt  = bus.stat_clr ? 1'b0 : r_sticky_tmo;
        w_fault_cnt_nxt   = bus.stat_clr ? '0   : r_fault_cnt;
        if (w_fault_berr || w_fault_tmo) begin
            w_fault_cnt_nxt = sat_inc_fcnt(w_fault_cnt_nxt);
        end
        if (w_fault_berr) begin
            w_sticky_berr_nxt = 1'b1;
        end
        if (w_fault_tmo) begin
            w_sticky_tmo_nxt = 1'b1;
        end
    end

    // Registered outputs and status bits
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_dma_abort   <= 1'b0;
            r_cycle_ok    <= 1'b0;
            r_busy        <= 1'b0;
            r_sticky_berr <= 1'b0;
            r_sticky_tmo  <= 1'b0;
            r_fault_cnt   <= '0;
        end else begin
            r_dma_abort   <= (w_state_nxt == MON_FAULT);
            r_cycle_ok    <= w_done;
            r_busy        <= (w_state_nxt != MON_IDLE);
            r_sticky_berr <= w_sticky_berr_nxt;
            r_sticky_tmo  <= w_sticky_tmo_nxt;
            r_fault_cnt   <= w_fault_cnt_nxt;
        end
    end

    // Assemble the STATUS word from registered bits only
    always_comb begin
        w_status                                = '0;
        w_status[c_STAT_BERR_BIT]               = r_sticky_berr;
        w_status[c_STAT_TMO_BIT]                = r_sticky_tmo;
        w_status[c_STAT_BUSY_BIT]               = r_busy;
        w_status[c_STAT_RSVD_BIT]               = 1'b0;
        w_status[c_STAT_CNT_MSB:c_STAT_CNT_LSB] = r_fault_cnt;
    end

    assign bus.dma_abort = r_dma_abort;
    assign bus.cycle_ok  = r_cycle_ok;
    assign bus.status    = w_status;

endmodule
`default_nettype wire

// File: tb/tb_dma_cycle_monitor.sv
`default_nettype none
// ============================================================================
//  Module      : tb_dma_cycle_monitor
//  Description : Self-checking bench for dma_cycle_monitor. Expected CYCLE_OK
//                edges are queued when DTACK is driven and consumed by the
//                output monitor; status/abort are checked against constants.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_dma_cycle_monitor;

    localparam int c_TIMEOUT = 16;
    localparam int c_SYNC    = 2;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   n_checks = 0;
    int   n_fail = 0;
    int   exp_q[$];
    int   t0;
    int   exp_cnt;

    dma_cycle_monitor_if bus();

    dma_cycle_monitor #(
        .TIMEOUT     (c_TIMEOUT),
        .SYNC_STAGES (c_SYNC)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #20 clk = ~clk;

    // Edge counter used to timestamp CYCLE_OK
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Start a cycle and let it run into the DTACK timeout
    task automatic run_to_timeout();
        bus.bmaster   = 1'b1;
        bus.dma_fcs_n = 1'b0;
        tick(1);
        tick(c_TIMEOUT);
    endtask

    // Output monitor: every CYCLE_OK pulse must match a queued expectation
    always @(negedge clk) begin
        if (bus.cycle_ok !== 1'b0) begin
            if (exp_q.size() == 0) begin
                check("cycle_ok_unexpected", int'(bus.cycle_ok), 0);
            end else begin
                check("cycle_ok_cycle", cyc, exp_q.pop_front());
            end
        end
    end

    initial begin
        bus.bmaster   = 1'b0;
        bus.dma_fcs_n = 1'b1;
        bus.dtack_n   = 1'b1;
        bus.berr_n    = 1'b1;
        bus.stat_clr  = 1'b0;

        // ---- reset state
        tick(3);
        check("rst_status", int'(bus.status), 'h00);
        check("rst_abort", int'(bus.dma_abort), 0);
        check("rst_cycle_ok", int'(bus.cycle_ok), 0);
        rst         = 1'b0;
        bus.bmaster = 1'b1;
        tick(2);
        check("idle_status", int'(bus.status), 'h00);

        // ---- normal cycle, DTACK captured on the 6th edge after entry
        bus.dma_fcs_n = 1'b0;
        tick(1);
        t0 = cyc;
        check("normal_busy", int'(bus.status), 'h20);
        tick(5);
        bus.dtack_n = 1'b0;
        exp_q.push_back(t0 + 6 + c_SYNC);
        for (int i = 0; i < 20 && exp_q.size() != 0; i++) tick(1);
        check("normal_ok_seen", exp_q.size(), 0);
        tick(2);
        check("normal_done_status", int'(bus.status), 'h20);
        check("normal_done_abort", int'(bus.dma_abort), 0);
        bus.dma_fcs_n = 1'b1;
        bus.dtack_n   = 1'b1;
        tick(1);
        check("normal_idle_status", int'(bus.status), 'h00);

        // ---- timeout
        bus.dma_fcs_n = 1'b0;
        tick(1);
        tick(c_TIMEOUT - 1);
        check("tmo_abort_early", int'(bus.dma_abort), 0);
        tick(1);
        check("tmo_abort", int'(bus.dma_abort), 1);
        check("tmo_status", int'(bus.status), 'h61);
        bus.dma_fcs_n = 1'b1;
        tick(1);
        check("tmo_abort_release", int'(bus.dma_abort), 0);
        check("tmo_idle_status", int'(bus.status), 'h41);

        // ---- status clear
        bus.stat_clr = 1'b1;
        tick(1);
        bus.stat_clr = 1'b0;
        check("clr_status", int'(bus.status), 'h00);

        // ---- bus error together with DTACK: error wins, no CYCLE_OK
        bus.dma_fcs_n = 1'b0;
        tick(3);
        bus.berr_n  = 1'b0;
        bus.dtack_n = 1'b0;
        tick(c_SYNC);
        check("berr_abort_sync", int'(bus.dma_abort), 0);
        tick(1);
        check("berr_abort", int'(bus.dma_abort), 1);
        check("berr_status", int'(bus.status), 'hA1);
        bus.berr_n    = 1'b1;
        bus.dtack_n   = 1'b1;
        bus.dma_fcs_n = 1'b1;
        tick(c_SYNC);
        check("berr_abort_hold", int'(bus.dma_abort), 1);
        tick(1);
        check("berr_abort_release", int'(bus.dma_abort), 0);
        check("berr_idle_status", int'(bus.status), 'h81);

        // ---- bus mastership lost while faulted
        run_to_timeout();
        check("bm_fault_status", int'(bus.status), 'hE2);
        bus.bmaster = 1'b0;
        tick(1);
        check("bm_drop_abort", int'(bus.dma_abort), 0);
        check("bm_drop_status", int'(bus.status), 'hC2);
        bus.dma_fcs_n = 1'b1;
        bus.bmaster   = 1'b1;
        tick(1);

        // ---- fault count saturation, then clear colliding with a fault
        bus.stat_clr = 1'b1;
        tick(1);
        bus.stat_clr = 1'b0;
        exp_cnt = 0;
        for (int k = 1; k <= 17; k++) begin
            run_to_timeout();
            exp_cnt = (exp_cnt == 15) ? 15 : exp_cnt + 1;
            check("sat_fault_cnt", int'(bus.status[3:0]), exp_cnt);
            bus.dma_fcs_n = 1'b1;
            tick(1);
        end
        bus.dma_fcs_n = 1'b0;
        tick(1);
        tick(c_TIMEOUT - 1);
        bus.stat_clr = 1'b1;
        tick(1);
        bus.stat_clr = 1'b0;
        check("clr_win_cnt", int'(bus.status[3:0]), 1);
        check("clr_win_tmo", int'(bus.status[6]), 1);
        check("clr_win_status", int'(bus.status), 'h61);
        bus.dma_fcs_n = 1'b1;
        tick(1);
        check("clr_win_idle", int'(bus.status), 'h41);

        // ---- reset mid-ACTIVE with DTACK arriving during reset
        bus.dma_fcs_n = 1'b0;
        tick(1);
        tick(5);
        bus.dtack_n = 1'b0;
        rst         = 1'b1;
        #1;
        check("midrst_status", int'(bus.status), 'h00);
        check("midrst_abort", int'(bus.dma_abort), 0);
        check("midrst_cycle_ok", int'(bus.cycle_ok), 0);
        tick(4);
        bus.dma_fcs_n = 1'b1;
        rst           = 1'b0;
        tick(6);
        bus.dtack_n = 1'b1;
        check("midrst_after_status", int'(bus.status), 'h00);
        check("sb_empty", exp_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
